decode: RTL and testbench
=========================

Name: decode

Overview:
- Register-fetch/decode stage of the Beta pipeline. Sits directly downstream of the fetch stage.
- Latches fetch's `pc_next`/`ir_next` into the IF/RF pipeline register, reads the register file and bypasses from ALU/MEM/WB.
- Resolves BEQ/BNE/JMP and illegal opcodes, returning redirect controls (`op_*`, `zr`, `br_addr`, `j_addr`) to fetch in the same cycle.
- Detects load-use hazards, stalls fetch, and drives the RF/ALU pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, reset value of `pc_rf` and `pc_alu`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  global freeze (memory wait); all stage registers hold
- pc_next  in  32  PC+4 of the instruction from fetch
- ir_next  in  32  instruction from fetch (`INST_NOP` when fetch squashes)
- ra_addr  out  5  register file read port 1 address
- rb_addr  out  5  register file read port 2 address
- ra_data  in  32  port 1 data (asynchronous read)
- rb_data  in  32  port 2 data (asynchronous read)
- alu_rc, mem_rc, wb_rc  in  5 each  destination register in ALU/MEM/WB stages
- alu_wen, mem_wen, wb_wen  in  1 each  stage will write its rc
- alu_is_load  in  1  ALU-stage instruction is LD/LDR
- alu_result, mem_result, wb_result  in  32 each  bypass values
- stall  out  1  to fetch: hold PC
- zr  out  1  bypassed Ra == 0
- op_ill, op_jmp, op_beq, op_bne  out  1 each  redirect controls to fetch
- br_addr  out  32  `pc_rf` + (sext(lit16) << 2)
- j_addr  out  32  bypassed Ra & ~32'h3
- pc_alu, ir_alu  out  32 each  RF/ALU register: PC+4 and instruction
- a_alu, b_alu, d_alu  out  32 each  RF/ALU register: operand A, operand B, store data

Behaviour:
- Field decode on `ir_rf`:
  - opc = [31:26], rc = [25:21], ra = [20:16], rb = [15:11], lit = [15:0].
- Register read addressing:
  - `ra_addr` = ra.
  - `rb_addr` = rc for ST (0x19), else rb.
- Bypass, per port:
  - Address 31 always yields 0.
  - Otherwise priority is ALU (alu_wen && alu_rc match), then MEM, then WB, then regfile data.
  - Combinational.
- Legal opcodes: 0x18, 0x19, 0x1B, 0x1D, 0x1E, 0x1F, 0x20–0x26, 0x28–0x2E, 0x30–0x36, 0x38–0x3E. All others are illegal.
- `load_use` = alu_is_load && alu_rc != 31 && (alu_rc == ra_addr || (port 2 used && alu_rc == rb_addr)).
  - Port 2 is used by opc 0x20–0x2F and ST.
  - Port 1 is used by all except LDR.
- `stall` = load_use | stall_in.
- Redirect controls, each qualified by ~stall:
  - `op_jmp` = (opc == 0x1B).
  - `op_beq` = (opc == 0x1D).
  - `op_bne` = (opc == 0x1E).
  - `op_ill` = illegal.
  - With `stall` high, all four are 0.
- Operand formation:
  - `a` = bypassed Ra. For LDR, `a` = br_addr.
  - `b` = sext(lit) for opc[31:30] == 2'b11, LD, ST. `b` = 0 for LDR and branches. Else bypassed port 2.
  - `d` = bypassed port 2 for ST, else 0.
- IF/RF register (`pc_rf`, `ir_rf`):
  - Loads `pc_next`/`ir_next` when stall == 0.
  - Holds when stall == 1.
  - On a taken branch/JMP/illegal it still loads; fetch supplies `INST_NOP` in that case.
- RF/ALU register update, in priority order:
  - stall_in = 1: hold all.
  - else load_use = 1: `ir_alu` <= `INST_NOP`, `pc_alu` <= `pc_rf`, a/b/d <= 0 (bubble).
  - else illegal: `ir_alu` <= `INST_BNE_EXCEPT`, `pc_alu` <= `pc_rf` (XP link = faulting PC+4), a/b/d <= 0.
  - else: load `pc_rf`, `ir_rf`, a, b, d.
- Branch/JMP link: passes `pc_rf` unchanged as `pc_alu`. The ALU stage writes it to rc.
- Latency:
  - Redirects are combinational in the same cycle as `ir_rf`.
  - Operands appear at the ALU stage 1 cycle after the instruction enters RF.
- Reset (rst_n low, asynchronous):
  - `ir_rf`, `ir_alu` = `INST_NOP`.
  - `pc_rf`, `pc_alu` = RESET_PC.
  - a/b/d = 0.
  - Combinational outputs follow from NOP: all op_* = 0, stall = 0.
  - Reset mid-stall discards held state.
- Simultaneous events:
  - load_use plus a branch in RF: stall wins. The branch is re-evaluated next cycle with the load result available via MEM bypass.
  - stall_in plus illegal: op_ill = 0 until the freeze clears.

Test Plan:
- Reset then release: `ir_alu` = `INST_NOP`, `pc_alu` = 0, `stall` = 0, all op_* = 0.
- ADD R1,R2,R3 with regfile R2=5, R3=7, no bypass → next cycle a_alu = 5, b_alu = 7, ir_alu = ADD.
- ADD reading R2 while ALU stage writes R2 = 9 and MEM writes R2 = 4 → a_alu = 9 (ALU priority). The same with rc = 31 in all stages → a_alu = 0.
- LD R4 in ALU stage (alu_is_load = 1, alu_rc = 4), SUB R5,R4,R6 in RF → stall = 1 for one cycle, ir_alu = NOP, `ir_rf` held. Next cycle SUB issues using mem_result.
- BEQ R1, offset −2 at pc_rf = 0x104 (PC+4), R1 = 0 → op_beq = 1, zr = 1, br_addr = 0xFC. With R1 = 3 → zr = 0.
- Opcode 0x27 at pc_rf = 0x40 → op_ill = 1, next cycle ir_alu = `INST_BNE_EXCEPT`, pc_alu = 0x40.
- Opcode 0x27 with stall_in = 1 → op_ill = 0, all registers hold.

Source files
------------

// File: rtl/decode.sv
// Beta pipeline register-fetch/decode stage.
// Holds the IF/RF and RF/ALU registers, bypasses operands,
// resolves BEQ/BNE/JMP/illegal redirects and load-use stalls.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall_in              global freeze, every stage register holds
//   pc_next, ir_next      PC+4 and instruction from fetch
//   ra_addr, rb_addr      register file read addresses
//   ra_data, rb_data      register file read data (async)
//   alu/mem/wb_rc,_wen    downstream destination and write enable
//   alu_is_load           ALU-stage instruction is LD/LDR
//   alu/mem/wb_result     bypass values
//   stall                 hold PC in fetch
//   zr                    bypassed Ra is zero
//   op_ill/jmp/beq/bne    redirect controls to fetch
//   br_addr, j_addr       branch and jump targets
//   pc_alu, ir_alu        RF/ALU register: PC+4 and instruction
//   a_alu, b_alu, d_alu   RF/ALU register: operands and store data
module decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic [31:0] pc_next,
    input  logic [31:0] ir_next,
    output logic [4:0]  ra_addr,
    output logic [4:0]  rb_addr,
    input  logic [31:0] ra_data,
    input  logic [31:0] rb_data,
    input  logic [4:0]  alu_rc,
    input  logic [4:0]  mem_rc,
    input  logic [4:0]  wb_rc,
    input  logic        alu_wen,
    input  logic        mem_wen,
    input  logic        wb_wen,
    input  logic        alu_is_load,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic        stall,
    output logic        zr,
    output logic        op_ill,
    output logic        op_jmp,
    output logic        op_beq,
    output logic        op_bne,
    output logic [31:0] br_addr,
    output logic [31:0] j_addr,
    output logic [31:0] pc_alu,
    output logic [31:0] ir_alu,
    output logic [31:0] a_alu,
    output logic [31:0] b_alu,
    output logic [31:0] d_alu
);

    // ADD(R31,R31,R31)
    localparam logic [31:0] INST_NOP = 32'h83FF_F800;
    // BNE(R31,...,XP): ALU stage links XP and takes the trap
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000;

    localparam logic [5:0] OPC_LD  = 6'h18;
    localparam logic [5:0] OPC_ST  = 6'h19;
    localparam logic [5:0] OPC_JMP = 6'h1B;
    localparam logic [5:0] OPC_BEQ = 6'h1D;
    localparam logic [5:0] OPC_BNE = 6'h1E;
    localparam logic [5:0] OPC_LDR = 6'h1F;

    localparam logic [4:0] R31 = 5'd31;

    logic [31:0] pc_rf;
    logic [31:0] ir_rf;

    logic [5:0]  opc;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] lit;
    logic [31:0] lit_sext;

    assign opc      = ir_rf[31:26];
    assign rc       = ir_rf[25:21];
    assign ra       = ir_rf[20:16];
    assign rb       = ir_rf[15:11];
    assign lit      = ir_rf[15:0];
    assign lit_sext = {{16{lit[15]}}, lit};

    logic is_ld;
    logic is_st;
    logic is_jmp;
    logic is_beq;
    logic is_bne;
    logic is_ldr;
    logic is_imm;
    logic illegal;

    always_comb begin
        is_ld  = (opc == OPC_LD);
        is_st  = (opc == OPC_ST);
        is_jmp = (opc == OPC_JMP);
        is_beq = (opc == OPC_BEQ);
        is_bne = (opc == OPC_BNE);
        is_ldr = (opc == OPC_LDR);
        is_imm = (opc[5:4] == 2'b11);
    end

    // Upper half of the map is legal except every xx111 slot.
    always_comb begin
        illegal = 1'b1;
        case (opc)
            OPC_LD, OPC_ST, OPC_JMP,
            OPC_BEQ, OPC_BNE, OPC_LDR:
                illegal = 1'b0;
            default:
                illegal = !(opc[5] && (opc[2:0] != 3'b111));
        endcase
    end

    // ST reads its data register through port 2.
    assign ra_addr = ra;
    assign rb_addr = is_st ? rc : rb;

    function automatic logic [31:0] bypass(
        input logic [4:0]  addr,
        input logic [31:0] rf_val
    );
        logic [31:0] v;
        if (addr == R31) begin
            v = '0;
        end else if (alu_wen && (alu_rc == addr)) begin
            v = alu_result;
        end else if (mem_wen && (mem_rc == addr)) begin
            v = mem_result;
        end else if (wb_wen && (wb_rc == addr)) begin
            v = wb_result;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    logic [31:0] ra_val;
    logic [31:0] rb_val;

    always_comb begin
        ra_val = bypass(ra_addr, ra_data);
        rb_val = bypass(rb_addr, rb_data);
    end

    assign zr      = (ra_val == '0);
    assign j_addr  = ra_val & ~32'h3;
    assign br_addr = pc_rf + {lit_sext[29:0], 2'b00};

    logic port1_used;
    logic port2_used;
    logic load_use;

    assign port1_used = !is_ldr;
    assign port2_used = (opc[5:4] == 2'b10) || is_st;

    // The loaded value only exists at MEM, so a consumer in RF
    // must wait one cycle and pick it up from the MEM bypass.
    always_comb begin
        load_use = 1'b0;
        if (alu_is_load && (alu_rc != R31)) begin
            load_use = (port1_used && (alu_rc == ra_addr))
                    || (port2_used && (alu_rc == rb_addr));
        end
    end

    assign stall = load_use | stall_in;

    assign op_jmp = !stall && is_jmp;
    assign op_beq = !stall && is_beq;
    assign op_bne = !stall && is_bne;
    assign op_ill = !stall && illegal;

    logic [31:0] a_next;
    logic [31:0] b_next;
    logic [31:0] d_next;

    always_comb begin
        a_next = is_ldr ? br_addr : ra_val;
        b_next = rb_val;
        if (is_imm || is_ld || is_st) begin
            b_next = lit_sext;
        end else if (is_ldr || is_jmp || is_beq || is_bne) begin
            b_next = '0;
        end
        d_next = is_st ? rb_val : '0;
    end

    // IF/RF: redirects still load, fetch has already squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_rf <= RESET_PC;
            ir_rf <= INST_NOP;
        end else if (!stall) begin
            pc_rf <= pc_next;
            ir_rf <= ir_next;
        end
    end

    // RF/ALU: bubbles and exceptions keep pc_rf so the
    // ALU stage can link the right PC+4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_alu <= RESET_PC;
            ir_alu <= INST_NOP;
            a_alu  <= '0;
            b_alu  <= '0;
            d_alu  <= '0;
        end else if (!stall_in) begin
            pc_alu <= pc_rf;
            if (load_use) begin
                ir_alu <= INST_NOP;
                a_alu  <= '0;
                b_alu  <= '0;
                d_alu  <= '0;
            end else if (illegal) begin
                ir_alu <= INST_BNE_EXCEPT;
                a_alu  <= '0;
                b_alu  <= '0;
                d_alu  <= '0;
            end else begin
                ir_alu <= ir_rf;
                a_alu  <= a_next;
                b_alu  <= b_next;
                d_alu  <= d_next;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage.
// Directed scenarios followed by randomized traffic vs. a model.
module tb_decode;

    localparam logic [31:0] NOP = 32'h83FF_F800;
    localparam logic [31:0] EXC = 32'h7BDF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_in;
    logic [31:0] pc_next;
    logic [31:0] ir_next;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic [4:0]  alu_rc;
    logic [4:0]  mem_rc;
    logic [4:0]  wb_rc;
    logic        alu_wen;
    logic        mem_wen;
    logic        wb_wen;
    logic        alu_is_load;
    logic [31:0] alu_result;
    logic [31:0] mem_result;
    logic [31:0] wb_result;
    logic        stall;
    logic        zr;
    logic        op_ill;
    logic        op_jmp;
    logic        op_beq;
    logic        op_bne;
    logic [31:0] br_addr;
    logic [31:0] j_addr;
    logic [31:0] pc_alu;
    logic [31:0] ir_alu;
    logic [31:0] a_alu;
    logic [31:0] b_alu;
    logic [31:0] d_alu;

    logic [31:0] regs [32];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .pc_next(pc_next), .ir_next(ir_next),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .alu_rc(alu_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
        .alu_wen(alu_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .alu_is_load(alu_is_load),
        .alu_result(alu_result), .mem_result(mem_result),
        .wb_result(wb_result),
        .stall(stall), .zr(zr),
        .op_ill(op_ill), .op_jmp(op_jmp),
        .op_beq(op_beq), .op_bne(op_bne),
        .br_addr(br_addr), .j_addr(j_addr),
        .pc_alu(pc_alu), .ir_alu(ir_alu),
        .a_alu(a_alu), .b_alu(b_alu), .d_alu(d_alu)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc_rf, m_ir_rf, m_pc_alu, m_ir_alu;
    logic [31:0] m_a, m_b, m_d;
    logic [4:0]  e_ra, e_rb;
    logic        e_stall, e_zr, e_lu, e_illegal;
    logic        e_ill, e_jmp, e_beq, e_bne;
    logic [31:0] e_br, e_j, e_a, e_b, e_d;

    function automatic logic [31:0] op3(input logic [5:0] o,
        input logic [4:0] c, input logic [4:0] a, input logic [4:0] b);
        return {o, c, a, b, 11'd0};
    endfunction

    function automatic logic [31:0] opl(input logic [5:0] o,
        input logic [4:0] c, input logic [4:0] a, input logic [15:0] l);
        return {o, c, a, l};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        logic [4:0]  rcs [3];
        logic        wen [3];
        logic [31:0] val [3];
        rcs = '{alu_rc, mem_rc, wb_rc};
        wen = '{alu_wen, mem_wen, wb_wen};
        val = '{alu_result, mem_result, wb_result};
        if (r == 5'd31) return 32'd0;
        for (int i = 0; i < 3; i++)
            if (wen[i] && rcs[i] == r) return val[i];
        return regs[r];
    endfunction

    task automatic model_reset();
        m_pc_rf = 0; m_ir_rf = NOP;
        m_pc_alu = 0; m_ir_alu = NOP;
        m_a = 0; m_b = 0; m_d = 0;
    endtask

    task automatic model_eval();
        logic [5:0] o;
        logic signed [15:0] l;
        logic [31:0] av, bv, sx;
        int off;
        bit u1, u2;
        o = m_ir_rf[31:26];
        l = m_ir_rf[15:0];
        e_ra = m_ir_rf[20:16];
        e_rb = (o == 6'h19) ? m_ir_rf[25:21] : m_ir_rf[15:11];
        av = fwd(e_ra);
        bv = fwd(e_rb);
        u1 = (o != 6'h1F);
        u2 = (o inside {[6'h20:6'h2F]}) || (o == 6'h19);
        e_lu = alu_is_load && alu_rc != 5'd31 &&
               ((u1 && alu_rc == e_ra) || (u2 && alu_rc == e_rb));
        e_stall = e_lu || stall_in;
        e_illegal = !(o inside {6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E,
            6'h1F, [6'h20:6'h26], [6'h28:6'h2E],
            [6'h30:6'h36], [6'h38:6'h3E]});
        e_jmp = !e_stall && o == 6'h1B;
        e_beq = !e_stall && o == 6'h1D;
        e_bne = !e_stall && o == 6'h1E;
        e_ill = !e_stall && e_illegal;
        off = l;
        sx = off;
        e_br = m_pc_rf + 32'(off * 4);
        e_zr = (av == 0);
        e_j = (av / 4) * 4;
        e_a = (o == 6'h1F) ? e_br : av;
        if (o >= 6'h30 || o == 6'h18 || o == 6'h19) e_b = sx;
        else if (o inside {6'h1B, 6'h1D, 6'h1E, 6'h1F}) e_b = 0;
        else e_b = bv;
        e_d = (o == 6'h19) ? bv : 0;
    endtask

    task automatic model_clock();
        if (!stall_in) begin
            m_pc_alu = m_pc_rf;
            if (e_lu) begin
                m_ir_alu = NOP; m_a = 0; m_b = 0; m_d = 0;
            end else if (e_illegal) begin
                m_ir_alu = EXC; m_a = 0; m_b = 0; m_d = 0;
            end else begin
                m_ir_alu = m_ir_rf; m_a = e_a; m_b = e_b; m_d = e_d;
            end
        end
        if (!e_stall) begin
            m_pc_rf = pc_next;
            m_ir_rf = ir_next;
        end
    endtask

    task automatic tick();
        model_eval();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stall_in = 0; alu_is_load = 0;
        alu_wen = 0; mem_wen = 0; wb_wen = 0;
        alu_rc = 31; mem_rc = 31; wb_rc = 31;
        alu_result = 0; mem_result = 0; wb_result = 0;
    endtask

    function automatic logic [4:0] rr();
        if ($urandom_range(0, 7) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        quiet();
        pc_next = 0; ir_next = NOP;
        for (int i = 0; i < 32; i++) regs[i] = 0;
        #1 rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ir_alu !== NOP) begin
            n_bad++;
            $display("FAIL rst_ir_alu: got %h want %h", ir_alu, NOP);
        end
        n_cmp++;
        if ({pc_alu, a_alu, b_alu, d_alu} !== 128'd0) begin
            n_bad++;
            $display("FAIL rst_regs: got %h %h %h %h want 0",
                pc_alu, a_alu, b_alu, d_alu);
        end
        rst_n = 1;
        tick();
        n_cmp++;
        if ({stall, op_ill, op_jmp, op_beq, op_bne} !== 5'd0) begin
            n_bad++;
            $display("FAIL rel_ctl: got %b want 00000",
                {stall, op_ill, op_jmp, op_beq, op_bne});
        end
        n_cmp++;
        if (ir_alu !== NOP || pc_alu !== 32'h0) begin
            n_bad++;
            $display("FAIL rel_alu: got %h/%h want %h/0",
                ir_alu, pc_alu, NOP);
        end
    endtask

    task automatic test_add();
        logic [31:0] add;
        add = op3(6'h20, 1, 2, 3);
        quiet();
        regs[2] = 5; regs[3] = 7;
        pc_next = 32'h104; ir_next = add;
        tick();
        pc_next = 32'h108; ir_next = NOP;
        #1;
        n_cmp++;
        if (ra_addr !== 5'd2 || rb_addr !== 5'd3) begin
            n_bad++;
            $display("FAIL add_addr: got %0d/%0d want 2/3",
                ra_addr, rb_addr);
        end
        tick();
        n_cmp++;
        if (a_alu !== 32'd5 || b_alu !== 32'd7) begin
            n_bad++;
            $display("FAIL add_ops: got %h/%h want 5/7", a_alu, b_alu);
        end
        n_cmp++;
        if (ir_alu !== add || pc_alu !== 32'h104) begin
            n_bad++;
            $display("FAIL add_ir: got %h/%h want %h/104",
                ir_alu, pc_alu, add);
        end
    endtask

    task automatic test_bypass();
        quiet();
        regs[2] = 5; regs[3] = 7;
        ir_next = op3(6'h20, 1, 2, 3);
        tick();
        ir_next = NOP;
        alu_wen = 1; alu_rc = 2; alu_result = 9;
        mem_wen = 1; mem_rc = 2; mem_result = 4;
        tick();
        n_cmp++;
        if (a_alu !== 32'd9) begin
            n_bad++;
            $display("FAIL byp_alu: got %h want 9", a_alu);
        end
        quiet();
        ir_next = op3(6'h20, 1, 2, 3);
        tick();
        ir_next = NOP;
        mem_wen = 1; mem_rc = 2; mem_result = 4;
        wb_wen = 1; wb_rc = 2; wb_result = 32'h77;
        tick();
        n_cmp++;
        if (a_alu !== 32'd4) begin
            n_bad++;
            $display("FAIL byp_mem: got %h want 4", a_alu);
        end
        quiet();
        regs[31] = 32'hDEAD_BEEF;
        ir_next = op3(6'h20, 1, 31, 31);
        tick();
        ir_next = NOP;
        alu_wen = 1; alu_rc = 31; alu_result = 9;
        mem_wen = 1; mem_rc = 31; mem_result = 4;
        wb_wen = 1; wb_rc = 31; wb_result = 3;
        tick();
        n_cmp++;
        if (a_alu !== 0 || b_alu !== 0) begin
            n_bad++;
            $display("FAIL byp_r31: got %h/%h want 0/0", a_alu, b_alu);
        end
        regs[31] = 0;
    endtask

    task automatic test_load_use();
        logic [31:0] sub;
        sub = op3(6'h21, 5, 4, 6);
        quiet();
        regs[6] = 3;
        pc_next = 32'h200; ir_next = sub;
        tick();
        pc_next = 32'h204; ir_next = NOP;
        alu_is_load = 1; alu_wen = 1; alu_rc = 4;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want 1", stall);
        end
        tick();
        n_cmp++;
        if (ir_alu !== NOP || pc_alu !== 32'h200 || ra_addr !== 5'd4) begin
            n_bad++;
            $display("FAIL lu_bubble: got %h/%h/%0d want %h/200/4",
                ir_alu, pc_alu, ra_addr, NOP);
        end
        alu_is_load = 0; alu_wen = 0; alu_rc = 31;
        mem_wen = 1; mem_rc = 4; mem_result = 32'h1234;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_release: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ir_alu !== sub || a_alu !== 32'h1234 || b_alu !== 32'd3) begin
            n_bad++;
            $display("FAIL lu_issue: got %h/%h/%h want %h/1234/3",
                ir_alu, a_alu, b_alu, sub);
        end
    endtask

    task automatic test_branch();
        logic [31:0] beq;
        beq = opl(6'h1D, 2, 1, 16'hFFFE);
        quiet();
        regs[1] = 0;
        pc_next = 32'h104; ir_next = beq;
        tick();
        pc_next = 32'h108; ir_next = NOP;
        #1;
        n_cmp++;
        if (op_beq !== 1 || zr !== 1 || br_addr !== 32'hFC) begin
            n_bad++;
            $display("FAIL beq_taken: got %b/%b/%h want 1/1/fc",
                op_beq, zr, br_addr);
        end
        regs[1] = 3;
        #1;
        n_cmp++;
        if (zr !== 0 || op_beq !== 1) begin
            n_bad++;
            $display("FAIL beq_nz: got zr=%b beq=%b want 0/1", zr, op_beq);
        end
        alu_is_load = 1; alu_rc = 1;
        #1;
        n_cmp++;
        if (stall !== 1 || op_beq !== 0) begin
            n_bad++;
            $display("FAIL beq_lu: got %b/%b want 1/0", stall, op_beq);
        end
        alu_is_load = 0; alu_rc = 31;
        tick();
        n_cmp++;
        if (ir_alu !== beq || pc_alu !== 32'h104 || b_alu !== 0) begin
            n_bad++;
            $display("FAIL beq_link: got %h/%h/%h want %h/104/0",
                ir_alu, pc_alu, b_alu, beq);
        end
        regs[7] = 32'h1237;
        ir_next = opl(6'h1B, 3, 7, 0); pc_next = 32'h300;
        tick();
        ir_next = NOP;
        #1;
        n_cmp++;
        if ({op_ill, op_jmp, op_beq, op_bne} !== 4'b0100
            || j_addr !== 32'h1234) begin
            n_bad++;
            $display("FAIL jmp: got %b/%h want 0100/1234",
                {op_ill, op_jmp, op_beq, op_bne}, j_addr);
        end
    endtask

    task automatic test_illegal();
        quiet();
        pc_next = 32'h40;
        ir_next = {6'h27, 26'($urandom)};
        tick();
        ir_next = NOP; pc_next = 32'h44;
        #1;
        n_cmp++;
        if (op_ill !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_flag: got %b want 1", op_ill);
        end
        tick();
        n_cmp++;
        if (ir_alu !== EXC || pc_alu !== 32'h40
            || {a_alu, b_alu, d_alu} !== 96'd0) begin
            n_bad++;
            $display("FAIL ill_exc: got %h/%h want %h/40",
                ir_alu, pc_alu, EXC);
        end
    endtask

    task automatic test_illegal_stall();
        logic [31:0] add, ill;
        add = op3(6'h20, 9, 2, 3);
        ill = {6'h27, 5'd1, 5'd12, 16'h0};
        quiet();
        ir_next = add; pc_next = 32'h7C;
        tick();
        ir_next = ill; pc_next = 32'h80;
        tick();
        ir_next = NOP; pc_next = 32'h84;
        stall_in = 1;
        #1;
        n_cmp++;
        if (op_ill !== 0 || stall !== 1) begin
            n_bad++;
            $display("FAIL frz_ctl: got ill=%b stall=%b want 0/1",
                op_ill, stall);
        end
        tick();
        tick();
        n_cmp++;
        if (ir_alu !== add || pc_alu !== 32'h7C || ra_addr !== 5'd12) begin
            n_bad++;
            $display("FAIL frz_hold: got %h/%h/%0d want %h/7c/12",
                ir_alu, pc_alu, ra_addr, add);
        end
        stall_in = 0;
        #1;
        n_cmp++;
        if (op_ill !== 1) begin
            n_bad++;
            $display("FAIL frz_clear: got %b want 1", op_ill);
        end
        stall_in = 1;
        #1 rst_n = 0;
        model_reset();
        #2;
        n_cmp++;
        if (ir_alu !== NOP || pc_alu !== 0 || ra_addr !== 5'd31) begin
            n_bad++;
            $display("FAIL frz_rst: got %h/%h/%0d want %h/0/31",
                ir_alu, pc_alu, ra_addr, NOP);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        quiet();
    endtask

    task automatic test_random();
        logic [5:0] ops [16];
        ops = '{6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F, 6'h20,
                6'h21, 6'h24, 6'h27, 6'h2A, 6'h30, 6'h35, 6'h3F,
                6'h00, 6'h10};
        for (int n = 0; n < 400; n++) begin
            n_cmp++;
            if ({pc_alu, ir_alu, a_alu, b_alu, d_alu} !==
                {m_pc_alu, m_ir_alu, m_a, m_b, m_d}) begin
                n_bad++;
                $display("FAIL rnd_regs[%0d]: got %h want %h", n,
                    {pc_alu, ir_alu, a_alu, b_alu, d_alu},
                    {m_pc_alu, m_ir_alu, m_a, m_b, m_d});
            end
            stall_in = ($urandom_range(0, 9) == 0);
            ir_next = {ops[$urandom_range(0, 15)], rr(), rr(), rr(),
                       11'($urandom)};
            pc_next = $urandom & ~32'h3;
            alu_rc = rr(); mem_rc = rr(); wb_rc = rr();
            alu_wen = 1'($urandom); mem_wen = 1'($urandom);
            wb_wen = 1'($urandom);
            alu_is_load = ($urandom_range(0, 2) == 0);
            alu_result = $urandom; mem_result = $urandom;
            wb_result = $urandom;
            for (int i = 0; i < 32; i++)
                regs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
            #1;
            model_eval();
            n_cmp++;
            if ({ra_addr, rb_addr, stall, zr, op_ill, op_jmp, op_beq,
                 op_bne, br_addr, j_addr} !==
                {e_ra, e_rb, e_stall, e_zr, e_ill, e_jmp, e_beq,
                 e_bne, e_br, e_j}) begin
                n_bad++;
                $display("FAIL rnd_comb[%0d]: got %h want %h", n,
                    {ra_addr, rb_addr, stall, zr, op_ill, op_jmp,
                     op_beq, op_bne, br_addr, j_addr},
                    {e_ra, e_rb, e_stall, e_zr, e_ill, e_jmp, e_beq,
                     e_bne, e_br, e_j});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bypass();
        test_load_use();
        test_branch();
        test_illegal();
        test_illegal_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
